// File: rtl/stream_merge_rr_2to1.sv
// Two-source packet stream merger with packet-granular round-robin arbitration.
// Once a source wins with a non-final beat it keeps the output until its
// last beat is accepted, so packets never interleave.
//
// state | meaning
// IDLE  | no packet in flight; pick a source from valids and the pointer
// LOCK0 | source 0 owns the output until its last beat is accepted
// LOCK1 | source 1 owns the output until its last beat is accepted
module stream_merge_rr_2to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;
    logic   sel_any;
    logic   sel_src;
    logic   load_ok;
    logic   acc;
    logic   acc_last;

    assign load_ok  = ~out_valid | out_ready;
    assign acc      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
    assign acc_last = sel_src ? in1_last : in0_last;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: lock on a non-final beat in IDLE, release on the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc && !acc_last) begin
                    state_nxt = sel_src ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (acc && acc_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Selection and readies; readies are gated by reset so they drop at once.
    always_comb begin
        sel_any = 1'b0;
        sel_src = 1'b0;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    sel_any = 1'b1;
                    sel_src = ptr;
                end else if (in0_valid) begin
                    sel_any = 1'b1;
                    sel_src = 1'b0;
                end else if (in1_valid) begin
                    sel_any = 1'b1;
                    sel_src = 1'b1;
                end
            end
            LOCK0: begin
                sel_any = 1'b1;
                sel_src = 1'b0;
            end
            LOCK1: begin
                sel_any = 1'b1;
                sel_src = 1'b1;
            end
            default: begin
                sel_any = 1'b0;
                sel_src = 1'b0;
            end
        endcase
        in0_ready = rst & load_ok & sel_any & ~sel_src;
        in1_ready = rst & load_ok & sel_any & sel_src;
    end

    // Priority pointer flips away from a source when its packet completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (acc && acc_last) begin
            ptr <= ~sel_src;
        end
    end

    // Output register: load on acceptance, empty when drained with nothing new.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (load_ok) begin
            out_valid <= acc;
            if (acc) begin
                out_data <= sel_src ? in1_data : in0_data;
                out_last <= acc_last;
                out_src  <= sel_src;
            end
        end
    end

endmodule

// File: tb/tb_stream_merge_rr_2to1.sv
// Randomized bench for stream_merge_rr_2to1 against a transaction-level
// reference model of the packet round-robin rules.
module tb_stream_merge_rr_2to1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iv [2];
    logic [7:0] id [2];
    logic       il [2];
    logic       in0_ready, in1_ready;
    logic       out_valid, out_last, out_src;
    logic [7:0] out_data;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         m_owner;   // -1 = no packet in flight, else owning source
    bit         m_ptr;
    bit         m_v, m_l, m_s;
    logic [7:0] m_d;
    bit         took [2];

    stream_merge_rr_2to1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (iv[0]),
        .in0_data  (id[0]),
        .in0_last  (il[0]),
        .in0_ready (in0_ready),
        .in1_valid (iv[1]),
        .in1_data  (id[1]),
        .in1_last  (il[1]),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 1'b0;
        m_v     = 1'b0;
        m_d     = 8'h00;
        m_l     = 1'b0;
        m_s     = 1'b0;
        took[0] = 1'b0;
        took[1] = 1'b0;
    endtask

    // Compare DUT against the model for the current cycle, then advance the model.
    task automatic step_model();
        int sel;
        bit lo;
        bit rdy [2];
        if (m_owner >= 0)          sel = m_owner;
        else if (iv[0] && iv[1])   sel = int'(m_ptr);
        else if (iv[0])            sel = 0;
        else if (iv[1])            sel = 1;
        else                       sel = -1;
        lo     = !m_v || out_ready;
        rdy[0] = lo && (sel == 0);
        rdy[1] = lo && (sel == 1);
        check("in0_ready", 32'(in0_ready), 32'(rdy[0]));
        check("in1_ready", 32'(in1_ready), 32'(rdy[1]));
        check("out_valid", 32'(out_valid), 32'(m_v));
        if (m_v) begin
            check("out_data", 32'(out_data), 32'(m_d));
            check("out_last", 32'(out_last), 32'(m_l));
            check("out_src",  32'(out_src),  32'(m_s));
        end
        took[0] = rdy[0] && iv[0];
        took[1] = rdy[1] && iv[1];
        if (lo) m_v = took[0] || took[1];
        if (took[0] || took[1]) begin
            m_d = id[sel];
            m_l = il[sel];
            m_s = (sel == 1);
            if (il[sel]) begin
                m_owner = -1;
                m_ptr   = (sel == 0);
            end else begin
                m_owner = sel;
            end
        end
    endtask

    // Random source/sink behaviour; unaccepted beats are usually held, sometimes withdrawn.
    task automatic drive(input int vpct, input int rpct);
        for (int s = 0; s < 2; s++) begin
            if (!(iv[s] && !took[s] && ($urandom_range(7) != 0))) begin
                iv[s] = ($urandom_range(99) < vpct);
                id[s] = 8'($urandom);
                il[s] = ($urandom_range(2) == 0);
            end
        end
        out_ready = ($urandom_range(99) < rpct);
    endtask

    task automatic cycle(input int vpct, input int rpct);
        @(posedge clk);
        #1;
        drive(vpct, rpct);
        @(negedge clk);
        step_model();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_src"},   32'(out_src),   32'd0);
        check({tag, "_in0_ready"}, 32'(in0_ready), 32'd0);
        check({tag, "_in1_ready"}, 32'(in1_ready), 32'd0);
    endtask

    initial begin
        iv[0] = 1'b1; iv[1] = 1'b1;
        id[0] = 8'h11; id[1] = 8'h22;
        il[0] = 1'b0; il[1] = 1'b0;
        out_ready = 1'b1;
        model_reset();
        #12;
        reset_checks("por");
        @(negedge clk);
        rst = 1'b1;
        #1;
        step_model();
        check("por_src0_first", 32'(in0_ready), 32'd1);

        for (int i = 0; i < 1500; i++) cycle(70, 75);
        for (int i = 0; i < 300; i++)  cycle(100, 100);
        for (int i = 0; i < 300; i++)  cycle(50, 30);

        // asynchronous reset in the middle of traffic
        iv[0] = 1'b1; iv[1] = 1'b1;
        il[0] = 1'b1; il[1] = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        reset_checks("mid");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        step_model();
        check("mid_src0_first", 32'(in0_ready), 32'd1);
        check("mid_src1_wait",  32'(in1_ready), 32'd0);

        for (int i = 0; i < 1500; i++) cycle(60, 70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
